// File: rtl/eyearch_pkg.sv
// Definitions shared by the fetch stage and the control unit:
// instruction field positions, the fetch state encoding and opcode constants.
package eyearch_pkg;

    localparam int OPC_W  = 6;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 10;
    localparam int RD_HI  = 9;
    localparam int RD_LO  = 7;
    localparam int RA_HI  = 6;
    localparam int RA_LO  = 4;
    localparam int RB_HI  = 3;
    localparam int RB_LO  = 1;
    localparam int IMM_HI = 6;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        FULL     = 2'd2
    } fetch_state_t;

    localparam logic [OPC_W-1:0] OP_NOP  = 6'b000000;
    localparam logic [OPC_W-1:0] OP_ADD  = 6'b000001;
    localparam logic [OPC_W-1:0] OP_LDIM = 6'b001110;

endpackage

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, reads imem over req/ack and holds one
// instruction whose decoded fields are offered to decode over valid/ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no request outstanding; launches a fetch unless halted
// WAIT_ACK | imem_req held at pc until imem_ack; kill drops the response
// FULL     | ir holds an instruction at pc, offered on out_valid
module ifetch
    import eyearch_pkg::*;
#(
    parameter int                INST_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [5:0]        opcode,
    output logic [2:0]        rd,
    output logic [2:0]        ra,
    output logic [2:0]        rb,
    output logic [6:0]        imm
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] ir;
    logic              kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!redirect && !halt) state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (imem_ack) state_nxt = (redirect || kill) ? IDLE : FULL;
            end
            FULL: begin
                if (redirect)       state_nxt = IDLE;
                else if (out_ready) state_nxt = halt ? IDLE : WAIT_ACK;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state == WAIT_ACK);
        out_valid = (state == FULL) && !redirect;
    end

    // A redirect during an outstanding read cannot cancel it, so kill marks
    // the eventual response as stale; with the ack in the same cycle it is
    // dropped right away instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc   <= RESET_PC;
            ir   <= '0;
            kill <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) pc <= redirect_pc;
                end
                WAIT_ACK: begin
                    if (redirect) begin
                        pc   <= redirect_pc;
                        kill <= !imem_ack;
                    end else if (imem_ack) begin
                        if (kill) kill <= 1'b0;
                        else      ir   <= imem_rdata;
                    end
                end
                FULL: begin
                    if (redirect) begin
                        ir <= '0;
                        pc <= redirect_pc;
                    end else if (out_ready) begin
                        pc <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc;
    assign out_pc    = pc;
    assign opcode    = ir[OPC_HI:OPC_LO];
    assign rd        = ir[RD_HI:RD_LO];
    assign ra        = ir[RA_HI:RA_LO];
    assign rb        = ir[RB_HI:RB_LO];
    assign imm       = ir[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: imem responses and downstream readiness are
// driven by hand and every output is compared to hand-computed values.
module tb_ifetch;
    import eyearch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pc;
    logic [5:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [6:0]  imm;

    int n_cmp = 0;
    int n_bad = 0;

    ifetch #(.INST_W(16), .ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .opcode      (opcode),
        .rd          (rd),
        .ra          (ra),
        .rb          (rb),
        .imm         (imm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Return one imem response in the cycle after the call.
    task automatic respond(input logic [15:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
    endtask

    initial begin
        rst_n       = 1'b0;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0000;
        out_ready   = 1'b0;
        step();
        step();
        check("rst_req",    {31'd0, imem_req},  32'd0);
        check("rst_valid",  {31'd0, out_valid}, 32'd0);
        check("rst_opcode", {26'd0, opcode},    32'd0);
        check("rst_imm",    {25'd0, imm},       32'd0);
        check("rst_pc",     {24'd0, out_pc},    32'd0);

        // First fetch: req on cycle 1, ack on cycle 2, valid on cycle 3.
        rst_n = 1'b1;
        step();
        check("c1_req",  {31'd0, imem_req},  32'd1);
        check("c1_addr", {24'd0, imem_addr}, 32'h00);
        step();
        check("c2_req_held", {31'd0, imem_req},  32'd1);
        check("c2_no_valid", {31'd0, out_valid}, 32'd0);
        respond(16'h0522);
        check("c3_valid",  {31'd0, out_valid}, 32'd1);
        check("c3_opcode", {26'd0, opcode},    {26'd0, OP_ADD});
        check("c3_rd",     {29'd0, rd},        32'd2);
        check("c3_ra",     {29'd0, ra},        32'd2);
        check("c3_rb",     {29'd0, rb},        32'd1);
        check("c3_imm",    {25'd0, imm},       32'h22);
        check("c3_out_pc", {24'd0, out_pc},    32'h00);
        check("c3_no_req", {31'd0, imem_req},  32'd0);

        // Stall downstream for 5 cycles; everything must hold.
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid",  {31'd0, out_valid}, 32'd1);
            check("stall_opcode", {26'd0, opcode},    32'd1);
            check("stall_rd",     {29'd0, rd},        32'd2);
            check("stall_pc",     {24'd0, out_pc},    32'h00);
            check("stall_no_req", {31'd0, imem_req},  32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("acc_req",   {31'd0, imem_req},  32'd1);
        check("acc_addr",  {24'd0, imem_addr}, 32'h01);
        check("acc_valid", {31'd0, out_valid}, 32'd0);

        respond(16'h3800);
        check("ldim_opcode", {26'd0, opcode}, {26'd0, OP_LDIM});
        check("ldim_rd",     {29'd0, rd},     32'd0);
        check("ldim_pc",     {24'd0, out_pc}, 32'h01);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        respond(16'h0000);
        check("nop_opcode", {26'd0, opcode}, {26'd0, OP_NOP});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("wait3_addr", {24'd0, imem_addr}, 32'h03);

        // Redirect while a read is outstanding: response two cycles later is stale.
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        step();
        redirect = 1'b0;
        check("kill_req_held", {31'd0, imem_req},  32'd1);
        check("kill_no_valid", {31'd0, out_valid}, 32'd0);
        step();
        respond(16'h3800);
        check("stale_no_valid", {31'd0, out_valid}, 32'd0);
        check("stale_no_req",   {31'd0, imem_req},  32'd0);
        check("stale_opcode",   {26'd0, opcode},    32'd0);
        step();
        check("refetch_req",  {31'd0, imem_req},  32'd1);
        check("refetch_addr", {24'd0, imem_addr}, 32'h40);

        // Redirect in FULL beats a simultaneous accept.
        respond(16'h0522);
        check("full40_valid", {31'd0, out_valid}, 32'd1);
        check("full40_pc",    {24'd0, out_pc},    32'h40);
        redirect    = 1'b1;
        redirect_pc = 8'hFF;
        out_ready   = 1'b1;
        #1;
        check("redir_valid_low", {31'd0, out_valid}, 32'd0);
        step();
        redirect  = 1'b0;
        out_ready = 1'b0;
        check("redir_idle_req",  {31'd0, imem_req},  32'd0);
        check("redir_idle_val",  {31'd0, out_valid}, 32'd0);
        check("redir_ir_drop",   {26'd0, opcode},    32'd0);
        check("redir_pc",        {24'd0, out_pc},    32'hFF);
        step();
        check("redir_fetch_req",  {31'd0, imem_req},  32'd1);
        check("redir_fetch_addr", {24'd0, imem_addr}, 32'hFF);

        // Accept at pc=FF wraps the next fetch to 00.
        respond(16'h0522);
        check("ff_out_pc", {24'd0, out_pc}, 32'hFF);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("wrap_req",  {31'd0, imem_req},  32'd1);
        check("wrap_addr", {24'd0, imem_addr}, 32'h00);

        // Halt during WAIT_ACK: the outstanding read still completes.
        halt = 1'b1;
        step();
        check("halt_req_held", {31'd0, imem_req}, 32'd1);
        respond(16'h0403);
        check("halt_fill_valid", {31'd0, out_valid}, 32'd1);
        check("halt_fill_rb",    {29'd0, rb},        32'd1);
        check("halt_fill_imm",   {25'd0, imm},       32'h03);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("halt_idle_req", {31'd0, imem_req},  32'd0);
            check("halt_idle_val", {31'd0, out_valid}, 32'd0);
            step();
        end
        halt = 1'b0;
        step();
        check("unhalt_req",  {31'd0, imem_req},  32'd1);
        check("unhalt_addr", {24'd0, imem_addr}, 32'h01);

        // Asynchronous reset mid-WAIT_ACK with an ack pending.
        imem_ack   = 1'b1;
        imem_rdata = 16'h0522;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_req",  {31'd0, imem_req},  32'd0);
        check("arst_addr", {24'd0, imem_addr}, 32'h00);
        check("arst_val",  {31'd0, out_valid}, 32'd0);
        step();
        check("arst_hold_val", {31'd0, out_valid}, 32'd0);
        check("arst_hold_opc", {26'd0, opcode},    32'd0);
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        rst_n      = 1'b1;
        step();
        check("post_rst_req",  {31'd0, imem_req},  32'd1);
        check("post_rst_addr", {24'd0, imem_addr}, 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
